mbist_fail_logger: RTL
======================

MBIST_FAIL_LOGGER -- requirements
Module: mbist_fail_logger

Interface
REQ-001 Parameter ADDR_W, default 6, SRAM address width.
REQ-002 Parameter DEPTH, default 4, fail-log FIFO entries (power of two, >=2).
REQ-003 Parameter CNT_W, default 8, fail counter width.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle pulse from MBIST controller; begins a test run.
REQ-007 test_done  input  1  one-cycle pulse; marks end of the run.
REQ-008 cmp_valid  input  1  the compare result, addr and data inputs are valid this cycle.
REQ-009 gt, eq, lt  input  1 each  comparator result flags (expected vs actual).
REQ-010 addr  input  ADDR_W  SRAM address of the compare.
REQ-011 data_t  input  8  expected data; ramout  input  8  actual SRAM data.
REQ-012 busy  output  1  high in RUN; done  output  1  high in DONE.
REQ-013 pass  output  1  high in DONE when fail_cnt == 0.
REQ-014 fail_cnt  output  CNT_W  saturating count of failing compares in the current run.
REQ-015 overflow  output  1  sticky; a fail was counted but not logged because the FIFO was full.
REQ-016 log_valid  output  1; log_ready  input  1  readout handshake for FIFO head.
REQ-017 log_addr  output  ADDR_W; log_exp  output  8; log_act  output  8  head entry fields.

Function
REQ-018 FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE on test_done; DONE->RUN on start.
REQ-019 start in RUN is ignored; test_done outside RUN is ignored.
REQ-020 Entering RUN clears fail_cnt, overflow and all FIFO contents in the same edge.
REQ-021 Fail event = state RUN & cmp_valid & ~eq; illegal flag combinations with eq=0 count as fails; eq=1 is pass regardless of gt/lt.
REQ-022 cmp_valid outside RUN is ignored.
REQ-023 On a fail event fail_cnt increments by one on the next edge and holds at 2^CNT_W-1.
REQ-024 On a fail event, if the FIFO is not full, {addr, data_t, ramout} is pushed; log_valid rises the cycle after.
REQ-025 On a fail event with FIFO full and no pop that cycle, the entry is dropped and overflow sets.
REQ-026 Pop occurs when log_valid & log_ready; push and pop in the same cycle with FIFO full both succeed, no overflow.
REQ-027 FIFO is first-in first-out; the log_* outputs show the head entry and are don't-care when log_valid=0.
REQ-028 Readout (pop) is allowed in every state; the FIFO keeps its contents through DONE and IDLE until the next start.
REQ-029 A fail event coincident with test_done is fully processed (counted and logged) before DONE.
REQ-030 start coincident with a pop in DONE: the clear takes priority; the FIFO is empty after the edge.
REQ-031 pass is 0 outside DONE.

Reset
REQ-032 rst_n low asynchronously forces IDLE, busy=0, done=0, pass=0, fail_cnt=0, overflow=0, log_valid=0, FIFO empty.
REQ-033 Reset asserted mid-RUN aborts the run; no state survives, and after release the block waits in IDLE for start.

Configuration
REQ-034 Macro MBIST_STOP_ON_FAIL_EN: when defined, adds output stop_req (1 bit, reset 0). stop_req rises the cycle after the first fail event in a run, stays high until the next start or reset, and all later fail events in that run are ignored (fail_cnt stays 1).
REQ-035 Without MBIST_STOP_ON_FAIL_EN, the stop_req port does not exist and every fail event is counted per REQ-023..025.

Verification
REQ-036 start, 16 compares all eq=1, test_done -> done=1, pass=1, fail_cnt=0, log_valid=0.
REQ-037 start, fail at addr 0x05 (exp 0xAA, act 0xAB, lt=1) -> next cycle fail_cnt=1, log_valid=1, log_addr=0x05, log_exp=0xAA, log_act=0xAB.
REQ-038 DEPTH=4, 6 fails with log_ready=0 -> fail_cnt=6, overflow=1; draining gives the first 4 addresses in order.
REQ-039 FIFO full, fail event with log_ready=1 in the same cycle -> overflow stays 0, count stays 4 entries, newest entry is at the tail.
REQ-040 CNT_W=8, 300 fails -> fail_cnt=255; rst_n pulse mid-RUN -> all outputs at reset values, start is required to resume.
REQ-041 MBIST_STOP_ON_FAIL_EN defined, fails at addr 3 and 7 -> stop_req=1, fail_cnt=1, one log entry with addr 3.

Source files
------------

// File: rtl/mbist_fail_logger.sv
// MBIST fail logger: run FSM, saturating fail counter and a fail-entry FIFO.
// Optional stop-on-first-fail behaviour is enabled with MBIST_STOP_ON_FAIL_EN.
module mbist_fail_logger #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              test_done,
  input  logic              cmp_valid,
  input  logic              gt,
  input  logic              eq,
  input  logic              lt,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        data_t,
  input  logic [7:0]        ramout,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              overflow,
  output logic              log_valid,
  input  logic              log_ready,
  output logic [ADDR_W-1:0] log_addr,
  output logic [7:0]        log_exp,
  output logic [7:0]        log_act
`ifdef MBIST_STOP_ON_FAIL_EN
  ,
  output logic              stop_req
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        exp;
    logic [7:0]        act;
  } entry_t;

  state_t state;
  state_t state_nxt;

  entry_t mem [DEPTH];
  entry_t head;
  entry_t wr_entry;

  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;

  logic run_go;
  logic stop_hold;
  logic fail_ev;
  logic full;
  logic empty;
  logic pop;
  logic push;
  logic drop;

  // gt/lt are informational only: eq alone decides pass or fail
  logic unused_flags;
  assign unused_flags = gt ^ lt;

  assign run_go = start & (state != RUN);

`ifdef MBIST_STOP_ON_FAIL_EN
  assign stop_hold = stop_req;
`else
  assign stop_hold = 1'b0;
`endif

  assign fail_ev = (state == RUN) & cmp_valid
                 & ~eq & ~stop_hold;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W])
               & (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign pop  = log_valid & log_ready;
  assign push = fail_ev & (~full | pop);
  assign drop = fail_ev & full & ~pop;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start)     state_nxt = RUN;
      RUN:  if (test_done) state_nxt = DONE;
      DONE: if (start)     state_nxt = RUN;
      default:             state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
    pass = (state == DONE) & (fail_cnt == '0);
  end

  // ---------------- counter / overflow ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_cnt <= '0;
      overflow <= 1'b0;
    end else if (run_go) begin
      fail_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (fail_ev && (fail_cnt != '1)) begin
        fail_cnt <= fail_cnt + 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef MBIST_STOP_ON_FAIL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stop_req <= 1'b0;
    end else if (run_go) begin
      stop_req <= 1'b0;
    end else if (fail_ev) begin
      stop_req <= 1'b1;
    end
  end
`endif

  // ---------------- FIFO ----------------
  // a new run clears the log even if a pop is requested on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (run_go) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_comb begin
    wr_entry      = '0;
    wr_entry.addr = addr;
    wr_entry.exp  = data_t;
    wr_entry.act  = ramout;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[PTR_W-1:0]] <= wr_entry;
    end
  end

  assign head      = mem[rd_ptr[PTR_W-1:0]];
  assign log_valid = ~empty;
  assign log_addr  = head.addr;
  assign log_exp   = head.exp;
  assign log_act   = head.act;

endmodule
